// File: rtl/mul_booth_pkg.sv
// Shared types and helpers for the sequential radix-2 Booth multiplier.
package mul_booth_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_e;

    typedef enum logic [1:0] {
        OP_NOP,
        OP_ADD,
        OP_SUB
    } op_e;

    // Step counter must hold the value BIT_LEN itself.
    function automatic int cnt_w(input int bit_len);
        return $clog2(bit_len + 1);
    endfunction

endpackage

// File: rtl/mul_booth_datapath.sv
// Booth datapath: operand/accumulator registers, add/sub and arithmetic shift.
module mul_booth_datapath
    import mul_booth_pkg::*;
#(
    parameter int BIT_LEN = 4
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   load_i,
    input  logic                   step_i,
    input  op_e                    op_i,
    input  logic [BIT_LEN-1:0]     in1_i,
    input  logic [BIT_LEN-1:0]     in2_i,
    output logic [1:0]             booth_o,
    output logic                   cnt_last_o,
    output logic [2*BIT_LEN-1:0]   prod_o
);

    localparam int CW = cnt_w(BIT_LEN);

    // One guard bit on M and A so (-2^(n-1))^2 cannot overflow the accumulator.
    logic [BIT_LEN:0]   m_q;
    logic [BIT_LEN:0]   a_q;
    logic [BIT_LEN:0]   a_sum;
    logic [BIT_LEN-1:0] q_q;
    logic               q1_q;
    logic [CW-1:0]      cnt_q;

    always_comb begin
        a_sum = a_q;
        case (op_i)
            OP_ADD:  a_sum = a_q + m_q;
            OP_SUB:  a_sum = a_q - m_q;
            default: a_sum = a_q;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_q   <= '0;
            a_q   <= '0;
            q_q   <= '0;
            q1_q  <= 1'b0;
            cnt_q <= '0;
        end else if (load_i) begin
            m_q   <= {in1_i[BIT_LEN-1], in1_i};
            a_q   <= '0;
            q_q   <= in2_i;
            q1_q  <= 1'b0;
            cnt_q <= CW'(BIT_LEN);
        end else if (step_i) begin
            a_q   <= {a_sum[BIT_LEN], a_sum[BIT_LEN:1]};
            q_q   <= {a_sum[0], q_q[BIT_LEN-1:1]};
            q1_q  <= q_q[0];
            cnt_q <= cnt_q - CW'(1);
        end
    end

    assign booth_o    = {q_q[0], q1_q};
    assign cnt_last_o = (cnt_q == CW'(1));
    assign prod_o     = {a_q[BIT_LEN-1:0], q_q};

endmodule

// File: rtl/mul_booth.sv
// Sequential radix-2 Booth multiplier: start/ready handshake, one step per clock.
module mul_booth
    import mul_booth_pkg::*;
#(
    parameter int BIT_LEN = 4
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 start,
    input  logic [BIT_LEN-1:0]   in1,
    input  logic [BIT_LEN-1:0]   in2,
    output logic [2*BIT_LEN-1:0] out,
    output logic                 out_r
);

    state_e     state_q, state_d;
    logic       out_r_q;
    logic       load;
    logic       step;
    op_e        op;
    logic [1:0] booth;
    logic       cnt_last;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            out_r_q <= 1'b0;
        end else begin
            state_q <= state_d;
            out_r_q <= (state_d == DONE);
        end
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        op      = OP_NOP;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = CALC;
                end
            end
            CALC: begin
                step = 1'b1;
                case (booth)
                    2'b01:   op = OP_ADD;
                    2'b10:   op = OP_SUB;
                    default: op = OP_NOP;
                endcase
                if (cnt_last) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    mul_booth_datapath #(
        .BIT_LEN(BIT_LEN)
    ) u_dp (
        .clk       (clk),
        .rstn      (rstn),
        .load_i    (load),
        .step_i    (step),
        .op_i      (op),
        .in1_i     (in1),
        .in2_i     (in2),
        .booth_o   (booth),
        .cnt_last_o(cnt_last),
        .prod_o    (out)
    );

    assign out_r = out_r_q;

endmodule

// File: tb/tb_mul_booth.sv
// Self-checking bench for mul_booth at BIT_LEN=4 (exhaustive) and BIT_LEN=8 (random).
module tb_mul_booth;

    logic        clk = 1'b0;
    logic        rstn;
    logic        start4, start8;
    logic [3:0]  a4, b4;
    logic [7:0]  out4;
    logic        rdy4;
    logic [7:0]  a8, b8;
    logic [15:0] out8;
    logic        rdy8;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mul_booth #(.BIT_LEN(4)) u_dut4 (
        .clk(clk), .rstn(rstn), .start(start4), .in1(a4), .in2(b4),
        .out(out4), .out_r(rdy4)
    );

    mul_booth #(.BIT_LEN(8)) u_dut8 (
        .clk(clk), .rstn(rstn), .start(start8), .in1(a8), .in2(b8),
        .out(out8), .out_r(rdy8)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: exact signed product truncated to 2*w bits.
    function automatic logic [31:0] ref_prod(input int a, input int b, input int w);
        longint p;
        p = longint'(a) * longint'(b);
        return 32'(p & ((64'd1 << (2 * w)) - 1));
    endfunction

    task automatic mul4(input logic signed [3:0] a, input logic signed [3:0] b, input string tag);
        @(negedge clk);
        a4 = a; b4 = b; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        a4 = $urandom; b4 = $urandom;
        repeat (3) @(posedge clk);
        #1 chk({tag, "_busy"}, {31'd0, rdy4}, 32'd0);
        @(posedge clk); #1;
        chk({tag, "_rdy"}, {31'd0, rdy4}, 32'd1);
        chk(tag, {24'd0, out4}, ref_prod(int'(a), int'(b), 4));
    endtask

    task automatic mul8(input logic signed [7:0] a, input logic signed [7:0] b);
        @(negedge clk);
        a8 = a; b8 = b; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        a8 = $urandom; b8 = $urandom;
        repeat (7) @(posedge clk);
        #1 chk("m8_busy", {31'd0, rdy8}, 32'd0);
        @(posedge clk); #1;
        chk("m8_rdy", {31'd0, rdy8}, 32'd1);
        chk("m8_prod", {16'd0, out8}, ref_prod(int'(a), int'(b), 8));
    endtask

    logic signed [3:0] opa [0:5];
    logic signed [3:0] opb [0:5];

    initial begin
        rstn = 1'b0; start4 = 1'b0; start8 = 1'b0;
        a4 = '0; b4 = '0; a8 = '0; b8 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out4", {24'd0, out4}, 32'd0);
        chk("rst_rdy4", {31'd0, rdy4}, 32'd0);
        chk("rst_out8", {16'd0, out8}, 32'd0);
        chk("rst_rdy8", {31'd0, rdy8}, 32'd0);
        @(negedge clk) rstn = 1'b1;

        // Directed corners
        mul4(4'sd7, -4'sd5, "m7xm5");
        repeat (3) @(posedge clk);
        #1;
        chk("hold_out", {24'd0, out4}, 32'h0000_00DD);
        chk("hold_rdy", {31'd0, rdy4}, 32'd1);
        mul4(-4'sd8, -4'sd8, "mneg_sq");
        mul4(-4'sd8, 4'sd7, "mneg_x7");
        mul4(4'sd7, 4'sd7, "m7x7");
        mul4(4'sd0, 4'($urandom), "mzero_a");
        mul4(4'($urandom), 4'sd0, "mzero_b");
        mul4(-4'sd1, -4'sd1, "mm1xm1");

        // Back-to-back with start held high; operands change during CALC.
        for (int i = 0; i < 6; i++) begin
            opa[i] = 4'($urandom);
            opb[i] = 4'($urandom);
        end
        @(negedge clk);
        a4 = opa[0]; b4 = opb[0]; start4 = 1'b1;
        @(posedge clk); #1;
        for (int j = 0; j < 5; j++) begin
            a4 = opa[j+1]; b4 = opb[j+1];
            repeat (3) @(posedge clk);
            #1 chk("b2b_busy", {31'd0, rdy4}, 32'd0);
            @(posedge clk); #1;
            chk("b2b_rdy", {31'd0, rdy4}, 32'd1);
            chk("b2b_prod", {24'd0, out4}, ref_prod(int'(opa[j]), int'(opb[j]), 4));
            @(posedge clk); #1;
            chk("b2b_drop", {31'd0, rdy4}, 32'd0);
        end
        start4 = 1'b0;
        repeat (5) @(posedge clk);

        // Reset in the middle of a calculation.
        @(negedge clk);
        a4 = 4'sd5; b4 = -4'sd3; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        repeat (2) @(posedge clk);
        #2 rstn = 1'b0;
        #1;
        chk("mid_rst_out", {24'd0, out4}, 32'd0);
        chk("mid_rst_rdy", {31'd0, rdy4}, 32'd0);
        @(negedge clk) rstn = 1'b1;
        repeat (3) @(posedge clk);
        #1 chk("idle_rdy", {31'd0, rdy4}, 32'd0);
        mul4(4'sd5, -4'sd3, "post_rst");

        // Exhaustive 4-bit sweep.
        for (int x = -8; x < 8; x++)
            for (int y = -8; y < 8; y++)
                mul4(4'(x), 4'(y), "sweep");

        // Random 8-bit pairs plus both extremes.
        mul8(-8'sd128, -8'sd128);
        mul8(-8'sd128, 8'sd127);
        for (int k = 0; k < 60; k++)
            mul8(8'($urandom), 8'($urandom));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
